// File: rtl/capture_sequencer.sv
// capture_sequencer: sequences one ADC capture into the sample RAM, then hands
// the RAM read port to the Nios until the host releases it. Tracks protocol
// violations in a sticky overrun flag and arbitrates the RAM read address.
module capture_sequencer #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs_adc,
   input  logic              user_take_sample,
   input  logic              read_new_sample,
   input  logic [ADDR_W-1:0] nios_read_addr,
   input  logic [ADDR_W-1:0] gui_read_addr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_owner,
   output logic              writing_finish_flag,
   output logic              busy,
   output logic              overrun
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   // Address of the final sample of a capture; issuing it ends the capture.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic              cs_q, take_q, rnew_q;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              rd_owner_q, rd_owner_d;
   logic              flag_q, flag_d;
   logic              busy_q, busy_d;
   logic              overrun_q, overrun_d;

   logic              rise_cs, rise_take, rise_rnew;

   // Inputs are already synchronous to clk; a held level gives one event.
   assign rise_cs   = cs_adc & ~cs_q;
   assign rise_take = user_take_sample & ~take_q;
   assign rise_rnew = read_new_sample & ~rnew_q;

   // Next-state, write-port and error-flag logic for the capture sequence.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      overrun_d = overrun_q;

      unique case (state_q)
         ST_IDLE: begin
            // A conversion edge coinciding with the take is deliberately dropped.
            if (rise_take) begin
               state_d   = ST_CAPTURE;
               cnt_d     = '0;
               wr_addr_d = '0;
            end
            if (rise_rnew) begin
               overrun_d = 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (rise_cs) begin
               wr_en_d   = 1'b1;
               wr_addr_d = cnt_q;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == LAST_ADDR) begin
                  state_d = ST_DONE;
               end
            end
            if (rise_take || rise_rnew) begin
               overrun_d = 1'b1;
            end
         end
         ST_DONE: begin
            // Release wins over a simultaneous take; the take only flags overrun.
            if (rise_rnew) begin
               state_d = ST_IDLE;
            end
            if (rise_take) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d     = (state_d == ST_CAPTURE);
      flag_d     = (state_d == ST_DONE);
      rd_owner_d = (state_d == ST_DONE);
      rd_addr_d  = (state_d == ST_DONE) ? nios_read_addr : gui_read_addr;
   end

   // State, edge-detect and registered-output update with async active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cs_q       <= 1'b0;
         take_q     <= 1'b0;
         rnew_q     <= 1'b0;
         cnt_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         rd_owner_q <= 1'b0;
         flag_q     <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cs_q       <= cs_adc;
         take_q     <= user_take_sample;
         rnew_q     <= read_new_sample;
         cnt_q      <= cnt_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         rd_owner_q <= rd_owner_d;
         flag_q     <= flag_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
      end
   end

   assign wr_en               = wr_en_q;
   assign wr_addr             = wr_addr_q;
   assign rd_addr             = rd_addr_q;
   assign rd_owner            = rd_owner_q;
   assign writing_finish_flag = flag_q;
   assign busy                = busy_q;
   assign overrun             = overrun_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with DEPTH=8, ADDR_W=4.
module tb_capture_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       cs_adc;
   logic       user_take_sample;
   logic       read_new_sample;
   logic [3:0] nios_read_addr;
   logic [3:0] gui_read_addr;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [3:0] rd_addr;
   logic       rd_owner;
   logic       writing_finish_flag;
   logic       busy;
   logic       overrun;

   int total = 0;
   int bad   = 0;

   capture_sequencer #(
      .ADDR_W(4),
      .DEPTH (8)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .cs_adc             (cs_adc),
      .user_take_sample   (user_take_sample),
      .read_new_sample    (read_new_sample),
      .nios_read_addr     (nios_read_addr),
      .gui_read_addr      (gui_read_addr),
      .wr_en              (wr_en),
      .wr_addr            (wr_addr),
      .rd_addr            (rd_addr),
      .rd_owner           (rd_owner),
      .writing_finish_flag(writing_finish_flag),
      .busy               (busy),
      .overrun            (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic take_pulse();
      user_take_sample = 1'b1;
      tick();
      chk("take_busy", busy, 1);
      chk("take_flag", writing_finish_flag, 0);
      user_take_sample = 1'b0;
      tick();
   endtask

   // One cs_adc rising edge, then 9 idle cycles (edges 10 cycles apart).
   task automatic cs_write(input logic [3:0] a, input logic last);
      cs_adc = 1'b1;
      tick();
      chk("wr_en_pulse", wr_en, 1);
      chk("wr_addr", wr_addr, a);
      chk("busy_after_edge", busy, !last);
      chk("flag_after_edge", writing_finish_flag, last);
      cs_adc = 1'b0;
      repeat (9) begin
         tick();
         chk("wr_en_idle", wr_en, 0);
      end
      chk("wr_addr_hold", wr_addr, a);
   endtask

   task automatic release_pulse();
      read_new_sample = 1'b1;
      tick();
      chk("release_flag", writing_finish_flag, 0);
      chk("release_owner", rd_owner, 0);
      read_new_sample = 1'b0;
      tick();
   endtask

   initial begin
      reset            = 1'b0;
      cs_adc           = 1'b0;
      user_take_sample = 1'b0;
      read_new_sample  = 1'b0;
      nios_read_addr   = 4'd0;
      gui_read_addr    = 4'd0;

      // Reset state
      tick();
      tick();
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_rd_owner", rd_owner, 0);
      chk("rst_flag", writing_finish_flag, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      reset = 1'b1;
      tick();

      // Reset mid-capture after three writes
      take_pulse();
      cs_write(4'd0, 1'b0);
      cs_write(4'd1, 1'b0);
      cs_write(4'd2, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_wr_addr", wr_addr, 0);
      chk("async_rst_flag", writing_finish_flag, 0);
      chk("async_rst_wr_en", wr_en, 0);
      tick();
      reset = 1'b1;
      tick();

      // Basic capture from address 0 after reset
      take_pulse();
      for (int i = 0; i < 8; i++) begin
         cs_write(4'(i), i == 7);
      end
      chk("done_flag", writing_finish_flag, 1);
      chk("done_busy", busy, 0);
      chk("done_owner", rd_owner, 1);

      // No write beyond DEPTH samples while in DONE
      cs_adc = 1'b1;
      tick();
      chk("done_no_write", wr_en, 0);
      chk("done_no_write_addr", wr_addr, 7);
      cs_adc = 1'b0;
      tick();

      // Handshake and arbitration
      nios_read_addr = 4'd5;
      gui_read_addr  = 4'd9;
      tick();
      chk("arb_nios_addr", rd_addr, 5);
      chk("arb_nios_owner", rd_owner, 1);
      read_new_sample = 1'b1;
      tick();
      chk("hs_flag", writing_finish_flag, 0);
      chk("hs_owner", rd_owner, 0);
      chk("hs_gui_addr", rd_addr, 9);
      chk("hs_overrun", overrun, 0);
      read_new_sample = 1'b0;
      tick();

      // Held levels: take held through a whole capture, cs held for 20 cycles
      user_take_sample = 1'b1;
      tick();
      chk("held_take_busy", busy, 1);
      chk("held_take_wr_addr", wr_addr, 0);
      cs_adc = 1'b1;
      tick();
      chk("held_cs_wr_en", wr_en, 1);
      chk("held_cs_wr_addr", wr_addr, 0);
      repeat (19) begin
         tick();
         chk("held_cs_single", wr_en, 0);
      end
      cs_adc = 1'b0;
      tick();
      for (int i = 1; i < 8; i++) begin
         cs_write(4'(i), i == 7);
      end
      chk("held_take_overrun_done", overrun, 0);
      read_new_sample = 1'b1;
      tick();
      chk("held_release_flag", writing_finish_flag, 0);
      read_new_sample = 1'b0;
      tick();
      chk("held_take_no_restart", busy, 0);
      chk("held_take_overrun", overrun, 0);
      user_take_sample = 1'b0;
      tick();

      // Overrun: take edge during CAPTURE
      take_pulse();
      cs_write(4'd0, 1'b0);
      cs_write(4'd1, 1'b0);
      cs_write(4'd2, 1'b0);
      user_take_sample = 1'b1;
      tick();
      chk("ovr_take_set", overrun, 1);
      chk("ovr_take_busy", busy, 1);
      user_take_sample = 1'b0;
      tick();
      for (int i = 3; i < 8; i++) begin
         cs_write(4'(i), i == 7);
      end
      chk("ovr_capture_done", writing_finish_flag, 1);
      release_pulse();

      // Overrun: rnew edge in IDLE is ignored, overrun stays
      read_new_sample = 1'b1;
      tick();
      chk("ovr_rnew_idle_busy", busy, 0);
      chk("ovr_rnew_idle_flag", writing_finish_flag, 0);
      chk("ovr_rnew_idle_sticky", overrun, 1);
      read_new_sample = 1'b0;
      repeat (3) tick();
      chk("ovr_sticky_later", overrun, 1);
      reset = 1'b0;
      #1;
      chk("ovr_cleared_by_reset", overrun, 0);
      tick();
      reset = 1'b1;
      tick();

      // Coincident take and cs in IDLE: that cs edge is not written
      user_take_sample = 1'b1;
      cs_adc           = 1'b1;
      tick();
      chk("coin_busy", busy, 1);
      chk("coin_no_write", wr_en, 0);
      user_take_sample = 1'b0;
      cs_adc           = 1'b0;
      tick();
      chk("coin_no_write2", wr_en, 0);
      for (int i = 0; i < 8; i++) begin
         cs_write(4'(i), i == 7);
      end
      chk("coin_overrun_clear", overrun, 0);

      // Coincident take and rnew in DONE: release wins, overrun set
      user_take_sample = 1'b1;
      read_new_sample  = 1'b1;
      tick();
      chk("coin_done_flag", writing_finish_flag, 0);
      chk("coin_done_busy", busy, 0);
      chk("coin_done_owner", rd_owner, 0);
      chk("coin_done_overrun", overrun, 1);
      user_take_sample = 1'b0;
      read_new_sample  = 1'b0;
      tick();
      chk("coin_done_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Sequences one capture of load-circuit ADC samples into the shared sample RAM, then hands the RAM read port to the Nios until the host releases it.
- Sits between the ADC block (cs_adc), the debounced user and Nios controls, and the sample RAM write and read ports.
- Produces the writing-finish flag that the Nios polls.
- Arbitrates the RAM read address between the GUI and the Nios.

Parameters:
- ADDR_W, 12, sample RAM address width.
- DEPTH, 4096, samples per capture; must satisfy 2 <= DEPTH <= 2^ADDR_W.

Ports:
- clk  in  1  system clock; all logic is in this domain.
- reset  in  1  asynchronous, active-low reset.
- cs_adc  in  1  ADC chip-select, synchronous to clk; a 0->1 transition marks a completed conversion with data valid.
- user_take_sample  in  1  debounced level; a rising edge requests a capture.
- read_new_sample  in  1  debounced level from the Nios; a rising edge means the host finished reading.
- nios_read_addr  in  ADDR_W  Nios read address.
- gui_read_addr  in  ADDR_W  GUI read address.
- wr_en  out  1  RAM write strobe, one-cycle pulse per stored sample.
- wr_addr  out  ADDR_W  RAM write address.
- rd_addr  out  ADDR_W  arbitrated RAM read address.
- rd_owner  out  1  read-port owner: 0 = GUI, 1 = Nios.
- writing_finish_flag  out  1  high while a complete capture is held for the host.
- busy  out  1  high in CAPTURE.
- overrun  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; sample counter 0; edge-detect registers 0.
- Edge detection:
  - cs_q, take_q and rnew_q register their inputs every cycle.
  - rise_x = x & ~x_q, evaluated combinationally.
  - A level held high produces exactly one event.
  - Inputs are already synchronous; no extra synchronizer.
- States and transitions:
  - IDLE: on rise_take, go to CAPTURE and clear the counter. A rise_cs in the same cycle is not stored.
  - CAPTURE (busy=1): on rise_cs, register wr_en=1 and wr_addr=counter for the next cycle, then counter++. When the sample at address DEPTH-1 is issued, go to DONE; that last wr_en pulse coincides with the first DONE cycle.
  - DONE: writing_finish_flag=1 from the cycle after the transition; on rise_rnew, go to IDLE and drop the flag the next cycle.
- Write port:
  - wr_en is 0 in every cycle without a qualifying rise_cs.
  - wr_addr holds its last value between pulses and returns to 0 only on reset or a new capture start.
  - The counter never wraps inside a capture; addresses 0..DEPTH-1 are each written exactly once, in order.
- Read arbitration:
  - rd_owner=1 in DONE, 0 otherwise, registered from state.
  - rd_addr is registered from nios_read_addr when the next-state is DONE, otherwise from gui_read_addr. Read latency is 1 cycle.
- Overrun (sticky until reset) is set on:
  - rise_take in CAPTURE or DONE; the request is ignored.
  - rise_rnew outside DONE; the event is ignored.
- Simultaneous events:
  - rise_take and rise_rnew together in DONE: release wins (go to IDLE); the take is ignored and sets overrun.
  - rise_cs with DONE entry: no extra write beyond DEPTH samples.
- Reset mid-capture: capture abandoned; RAM contents undefined to the host; writing_finish_flag stays 0 until a full capture completes.

Test Plan:
- Use DEPTH=8, ADDR_W=4 throughout.
- Reset mid-capture: assert reset after 3 writes -> all outputs 0 asynchronously; after release, a new take writes from address 0.
- Basic capture: after reset, pulse user_take_sample, then 8 cs_adc rising edges spaced 10 cycles apart -> 8 single-cycle wr_en pulses with wr_addr 0..7, each one cycle after the edge; busy is 1 from the take until the 8th edge; writing_finish_flag=1 after the 8th.
- Handshake and arbitration:
  - In DONE, drive nios_read_addr=5 and gui_read_addr=9 -> rd_addr=5 and rd_owner=1.
  - Raise read_new_sample -> flag=0 one cycle later, rd_owner=0, rd_addr=9.
- Held levels:
  - Hold cs_adc high for 20 cycles -> exactly one write.
  - Hold user_take_sample high through a whole capture -> no second capture, overrun stays 0.
- Overrun:
  - Take edge during CAPTURE after 3 writes -> capture continues to address 7, overrun=1.
  - read_new_sample edge in IDLE -> ignored, overrun stays 1 until reset.
- Coincident events:
  - Take and cs rise in the same IDLE cycle -> that cs edge is not written; the next edge writes address 0.
  - Take and rnew edges together in DONE -> IDLE, overrun=1.
